// File: rtl/ins_mem_pkg.sv
// ins_mem_pkg
// Shared definitions for the instruction fetch memory: the controller state
// encoding and the default geometry constants used by the top and the array.
package ins_mem_pkg;

    // CLEAR: hardware sweep is writing CLR_VAL through the whole array.
    // IDLE : normal operation, fetches and program loads are accepted.
    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/ins_mem_array.sv
// ins_mem_array
// 2**ADDR_W x DATA_W storage, one synchronous write port and one synchronous
// read-first read port. No reset on the storage or the read register.
// Ports:
//   clk    - rising-edge clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata updates only when re is high
//   raddr  - read address
//   rdata  - registered read data (old word on a same-address write)
module ins_mem_array
    import ins_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Both ports sample the array before the edge, so a same-address write
    // and read returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ins_fetch_mem.sv
// ins_fetch_mem
// Instruction memory with a registered fetch port, valid/ready handshakes,
// a runtime program-load port and a hardware clear sweep after reset or on
// clr_start.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - fetch request handshake, req_addr is the address
//   rsp_valid/rsp_ready   - response handshake, rsp_data is the instruction
//   wr_en/wr_addr/wr_data - program-load write, accepted while wr_ready
//   clr_start             - pulse requesting a full clear sweep
//   busy                  - clear sweep in progress
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and a held response keeps its
// data stable until rsp_ready takes it.
module ins_fetch_mem
    import ins_mem_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic              fetch_hs;
    logic              has_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    // State register and sweep counter. The counter wraps to 0 on the last
    // sweep write, so it is already 0 whenever a new sweep begins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        busy       = 1'b1;
        case (state)
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                wr_ready = 1'b1;
                busy     = 1'b0;
                if (clr_start) begin
                    state_next = CLEAR;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    assign req_ready = (state == IDLE) && (!rsp_valid || rsp_ready);
    assign fetch_hs  = req_valid && req_ready;

    // The sweep owns the write port while clearing; load writes are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = CLR_VAL;
        end else if (wr_en) begin
            mem_we = 1'b1;
        end
    end

    ins_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (fetch_hs),
        .raddr (req_addr),
        .rdata (rd_word)
    );

    // The array read register has no reset; has_data masks it to zero until
    // the first fetch after reset has loaded it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            has_data  <= 1'b0;
        end else begin
            if (fetch_hs) begin
                rsp_valid <= 1'b1;
                has_data  <= 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_data = has_data ? rd_word : '0;

endmodule

// File: tb/tb_ins_fetch_mem.sv
// tb_ins_fetch_mem
// Directed bench for ins_fetch_mem at default parameters (8-bit words,
// 16 entries). Inputs change on the falling edge, outputs are checked on the
// falling edge before the inputs change.
module tb_ins_fetch_mem;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       clr_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ins_fetch_mem dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_start (clr_start),
        .busy      (busy)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then back to the falling edge for checking/driving
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_start = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset values
        check("rst_busy", busy, 1);
        check("rst_req_ready", req_ready, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);

        // sweep after reset release: 16 busy cycles
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("sweep_busy", busy, 1);
            check("sweep_req_ready", req_ready, 0);
            step();
        end
        check("post_sweep_busy", busy, 0);
        check("post_sweep_req_ready", req_ready, 1);
        check("post_sweep_wr_ready", wr_ready, 1);

        // back-to-back fetch of 0..15, all zero
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd0;
        step();
        for (int a = 1; a < 16; a++) begin
            check("zero_rsp_valid", rsp_valid, 1);
            check("zero_rsp_data", rsp_data, 8'h00);
            req_addr = a[3:0];
            step();
        end
        check("zero_rsp_data_last", rsp_data, 8'h00);
        req_valid = 1'b0;
        step();
        check("idle_rsp_valid", rsp_valid, 0);

        // program load then fetch with 1-cycle latency
        write_word(4'd3, 8'hD7);
        req_valid = 1'b1;
        req_addr  = 4'd3;
        step();
        req_valid = 1'b0;
        check("load_rsp_valid", rsp_valid, 1);
        check("load_rsp_data", rsp_data, 8'hD7);
        step();

        // same-cycle write and fetch: read-first
        write_word(4'd5, 8'h11);
        wr_en     = 1'b1;
        wr_addr   = 4'd5;
        wr_data   = 8'hAA;
        req_valid = 1'b1;
        req_addr  = 4'd5;
        step();
        wr_en = 1'b0;
        check("rf_old_word", rsp_data, 8'h11);
        step();
        check("rf_new_word", rsp_data, 8'hAA);
        req_valid = 1'b0;
        step();

        // backpressure
        write_word(4'd2, 8'h22);
        write_word(4'd4, 8'h44);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 4'd2;
        step();
        req_addr = 4'd4;
        for (int i = 0; i < 3; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_data", rsp_data, 8'h22);
            check("bp_req_ready", req_ready, 0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_req_ready_release", req_ready, 1);
        step();
        check("bp_next_valid", rsp_valid, 1);
        check("bp_next_data", rsp_data, 8'h44);
        req_valid = 1'b0;
        step();
        check("bp_drain_valid", rsp_valid, 0);

        // fill with FF, then clear with a fetch pending across the sweep start
        for (int a = 0; a < 16; a++) begin
            write_word(a[3:0], 8'hFF);
        end
        clr_start = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd7;
        rsp_ready = 1'b0;
        step();
        clr_start = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("clr_busy", busy, 1);
            check("clr_wr_ready", wr_ready, 0);
            if (i == 0) begin
                check("clr_pending_valid", rsp_valid, 1);
                check("clr_pending_data", rsp_data, 8'hFF);
                check("clr_req_ready", req_ready, 0);
                rsp_ready = 1'b1;
            end
            // load writes during the sweep must be dropped
            wr_en   = 1'b1;
            wr_addr = i[3:0];
            wr_data = 8'h5A;
            req_valid = 1'b1;
            req_addr  = i[3:0];
            step();
            req_valid = 1'b0;
        end
        wr_en = 1'b0;
        check("clr_done_busy", busy, 0);
        check("clr_no_fetch_valid", rsp_valid, 0);
        req_valid = 1'b1;
        req_addr  = 4'd0;
        step();
        for (int a = 1; a < 16; a++) begin
            check("clr_rsp_data", rsp_data, 8'h00);
            req_addr = a[3:0];
            step();
        end
        check("clr_rsp_data_last", rsp_data, 8'h00);
        req_valid = 1'b0;
        step();

        // reset at sweep count 7 with a pending response
        write_word(4'd9, 8'h9C);
        clr_start = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd9;
        rsp_ready = 1'b0;
        step();
        clr_start = 1'b0;
        req_valid = 1'b0;
        check("mid_pending_valid", rsp_valid, 1);
        for (int i = 0; i < 7; i++) begin
            step();
        end
        reset = 1'b1;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_data", rsp_data, 8'h00);
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("restart_busy", busy, 1);
            check("restart_rsp_valid", rsp_valid, 0);
            step();
        end
        check("restart_done_busy", busy, 0);
        check("restart_rsp_valid_end", rsp_valid, 0);
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4'd9;
        step();
        req_valid = 1'b0;
        check("restart_cleared_data", rsp_data, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
